// File: rtl/fetch_decode_queue_pkg.sv
// Shared fetch/decode pipeline types and constants used by the instruction
// queue and its pointer controller.
package fetch_decode_queue_pkg;

  localparam int FD_ADDRESS_WIDTH     = 64;
  localparam int FD_INSTRUCTION_WIDTH = 32;

  localparam logic [FD_INSTRUCTION_WIDTH-1:0] INSTR_NOP = 32'h00000013;
  localparam logic [FD_INSTRUCTION_WIDTH-1:0] HALT_WORD = '0;

  typedef struct packed {
    logic [FD_ADDRESS_WIDTH-1:0]     pcplus1;
    logic [FD_INSTRUCTION_WIDTH-1:0] instruction;
  } fd_entry_t;

endpackage

// File: rtl/fetch_decode_queue_fifo_ptr_ctrl.sv
// Read/write pointer and occupancy bookkeeping for the instruction queue.
// Flush overrides push and pop; push is refused when full or halted.
module fifo_ptr_ctrl #(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_req,
  input  logic             pop_req,
  input  logic             flush,
  input  logic             halted,
  output logic             push,
  output logic             pop,
  output logic             fetch_enable,
  output logic             not_empty,
  output logic [PTR_W-1:0] wr_ptr,
  output logic [PTR_W-1:0] rd_ptr,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  logic full;

  assign full         = (count == FULL_COUNT);
  assign not_empty    = (count != '0);
  assign fetch_enable = !full && !halted;
  assign push         = push_req && fetch_enable && !flush;
  assign pop          = pop_req && not_empty && !flush;

  // Pointers are exactly log2(DEPTH) bits, so increments wrap on their own.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/fetch_decode_queue.sv
// Instruction queue between fetch and decode: circular buffer of
// {pcplus1, instruction} with first-word fall-through, flush and halt latch.
module fetch_decode_queue
  import fetch_decode_queue_pkg::*;
#(
  parameter int DEPTH             = 4,
  parameter int ADDRESS_WIDTH     = 64,
  parameter int INSTRUCTION_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  input  logic [INSTRUCTION_WIDTH-1:0] in_instruction_bits,
  input  logic [ADDRESS_WIDTH-1:0]     in_pcplus1,
  input  logic                         in_flush,
  output logic                         out_fetch_enable,
  input  logic                         in_decode_ready,
  output logic                         out_valid,
  output logic [INSTRUCTION_WIDTH-1:0] out_instruction_bits,
  output logic [ADDRESS_WIDTH-1:0]     out_pc,
  output logic [ADDRESS_WIDTH-1:0]     out_pcplus1,
  output logic [$clog2(DEPTH):0]       out_count,
  output logic                         out_halted
);

  localparam int PTR_W = $clog2(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("fetch_decode_queue: DEPTH must be a power of two and at least 2");
  end
  if (ADDRESS_WIDTH != FD_ADDRESS_WIDTH ||
      INSTRUCTION_WIDTH != FD_INSTRUCTION_WIDTH) begin : g_bad_width
    $error("fetch_decode_queue: widths must match fd_entry_t");
  end

  fd_entry_t        mem [DEPTH];
  fd_entry_t        head;
  logic             push;
  logic             pop;
  logic             halted;
  logic             not_empty;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  fifo_ptr_ctrl #(.DEPTH(DEPTH)) u_ptr_ctrl (
    .clk          (clk),
    .reset        (reset),
    .push_req     (in_valid),
    .pop_req      (in_decode_ready),
    .flush        (in_flush),
    .halted       (halted),
    .push         (push),
    .pop          (pop),
    .fetch_enable (out_fetch_enable),
    .not_empty    (not_empty),
    .wr_ptr       (wr_ptr),
    .rd_ptr       (rd_ptr),
    .count        (out_count)
  );

  // NOTE: the data array has no reset; occupancy alone decides validity,
  // and stale contents are masked off the head outputs below.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{pcplus1: in_pcplus1, instruction: in_instruction_bits};
  end

  // A zero word still enqueues; it only stops further fetches.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                                            halted <= 1'b0;
    else if (in_flush)                                                    halted <= 1'b0;
    else if (push && in_instruction_bits == INSTRUCTION_WIDTH'(HALT_WORD)) halted <= 1'b1;
  end

  assign head                 = mem[rd_ptr];
  assign out_valid            = not_empty;
  assign out_halted           = halted;
  assign out_instruction_bits = not_empty ? head.instruction : '0;
  assign out_pcplus1          = not_empty ? head.pcplus1 : '0;
  assign out_pc               = not_empty ? head.pcplus1 - ADDRESS_WIDTH'(4) : '0;

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Scoreboard bench for fetch_decode_queue: accepted words are queued as
// expectations and compared whenever decode consumes the head.
module tb_fetch_decode_queue;
  import fetch_decode_queue_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_instruction_bits;
  logic [63:0] in_pcplus1;
  logic        in_flush;
  logic        out_fetch_enable;
  logic        in_decode_ready;
  logic        out_valid;
  logic [31:0] out_instruction_bits;
  logic [63:0] out_pc;
  logic [63:0] out_pcplus1;
  logic [2:0]  out_count;
  logic        out_halted;

  always #5 clk = ~clk;

  fetch_decode_queue #(.DEPTH(DEPTH), .ADDRESS_WIDTH(64), .INSTRUCTION_WIDTH(32)) dut (
    .clk                  (clk),
    .reset                (reset),
    .in_valid             (in_valid),
    .in_instruction_bits  (in_instruction_bits),
    .in_pcplus1           (in_pcplus1),
    .in_flush             (in_flush),
    .out_fetch_enable     (out_fetch_enable),
    .in_decode_ready      (in_decode_ready),
    .out_valid            (out_valid),
    .out_instruction_bits (out_instruction_bits),
    .out_pc               (out_pc),
    .out_pcplus1          (out_pcplus1),
    .out_count            (out_count),
    .out_halted           (out_halted)
  );

  typedef struct {
    logic [63:0] pcp;
    logic [31:0] ins;
  } exp_t;

  exp_t exp_q[$];
  bit   exp_halted;
  int   checks;
  int   errors;
  int   pops;

  // Called just after a falling edge: drive, compare any consumed head
  // against the scoreboard, update the expectation, advance one clock.
  task automatic drive_cycle(input logic v, input logic [31:0] ins, input logic [63:0] pcp,
                             input logic rdy, input logic fl);
    int   n;
    bit   fe;
    exp_t e;
    n  = exp_q.size();
    fe = (n < DEPTH) && !exp_halted;
    in_valid = v; in_instruction_bits = ins; in_pcplus1 = pcp;
    in_decode_ready = rdy; in_flush = fl;
    #1;
    checks++;
    if (out_fetch_enable !== fe) begin
      errors++;
      $display("FAIL fetch_enable got %b exp %b", out_fetch_enable, fe);
    end
    if (n != 0 && rdy && !fl) begin
      e = exp_q.pop_front();
      pops++;
      checks++;
      if (out_valid !== 1'b1 || out_instruction_bits !== e.ins ||
          out_pcplus1 !== e.pcp || out_pc !== e.pcp - 64'd4) begin
        errors++;
        $display("FAIL head_pop got v=%b ins=%h pcp=%h pc=%h exp ins=%h pcp=%h pc=%h",
                 out_valid, out_instruction_bits, out_pcplus1, out_pc,
                 e.ins, e.pcp, e.pcp - 64'd4);
      end
    end
    if (fl) begin
      exp_q.delete();
      exp_halted = 1'b0;
    end else if (v && fe) begin
      e.ins = ins; e.pcp = pcp;
      exp_q.push_back(e);
      if (ins == 32'h0) exp_halted = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in_valid = 1'b0; in_instruction_bits = '0; in_pcplus1 = '0;
    in_flush = 1'b0; in_decode_ready = 1'b0;
    exp_halted = 1'b0;
    #2;
    checks++;
    if (out_valid !== 1'b0 || out_fetch_enable !== 1'b1 || out_count !== 3'd0 ||
        out_halted !== 1'b0 || out_instruction_bits !== 32'h0 || out_pc !== 64'h0 ||
        out_pcplus1 !== 64'h0) begin
      errors++;
      $display("FAIL reset_state got v=%b fe=%b cnt=%0d h=%b ins=%h pc=%h exp 0 1 0 0 0 0",
               out_valid, out_fetch_enable, out_count, out_halted, out_instruction_bits, out_pc);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_fill();
    logic [31:0] words [4] = '{32'h00500093, 32'h00a00113, 32'h00f00193, 32'h01400213};
    for (int i = 0; i < 4; i++) drive_cycle(1'b1, words[i], 64'(4 * (i + 1)), 1'b0, 1'b0);
    checks++;
    if (out_count !== 3'd4 || out_fetch_enable !== 1'b0) begin
      errors++;
      $display("FAIL fill_full got cnt=%0d fe=%b exp cnt=4 fe=0", out_count, out_fetch_enable);
    end
    checks++;
    if (out_instruction_bits !== 32'h00500093 || out_pc !== 64'h0) begin
      errors++;
      $display("FAIL fill_head got ins=%h pc=%h exp ins=00500093 pc=0", out_instruction_bits, out_pc);
    end
    drive_cycle(1'b1, 32'hdeadbeef, 64'd20, 1'b0, 1'b0);
    checks++;
    if (out_count !== 3'd4) begin
      errors++;
      $display("FAIL fill_fifth_ignored got cnt=%0d exp 4", out_count);
    end
    drive_cycle(1'b0, '0, '0, 1'b1, 1'b0);
    checks++;
    if (out_fetch_enable !== 1'b1 || out_count !== 3'd3) begin
      errors++;
      $display("FAIL fill_first_pop got fe=%b cnt=%0d exp fe=1 cnt=3", out_fetch_enable, out_count);
    end
    for (int i = 0; i < 3; i++) drive_cycle(1'b0, '0, '0, 1'b1, 1'b0);
    checks++;
    if (out_count !== 3'd0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL fill_drained got cnt=%0d v=%b exp 0 0", out_count, out_valid);
    end
  endtask

  task automatic test_stream();
    int start_pops = pops;
    for (int i = 0; i < 20; i++) begin
      drive_cycle(1'b1, 32'h00100000 + 32'(i * 32'h113), 64'h1000 + 64'(4 * i), 1'b1, 1'b0);
      checks++;
      if (out_count !== 3'd1 || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL stream_count cycle %0d got cnt=%0d v=%b exp 1 1", i, out_count, out_valid);
      end
    end
    drive_cycle(1'b0, '0, '0, 1'b1, 1'b0);
    checks++;
    if (pops - start_pops != 20 || out_count !== 3'd0) begin
      errors++;
      $display("FAIL stream_total got pops=%0d cnt=%0d exp 20 0", pops - start_pops, out_count);
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) drive_cycle(1'b1, 32'h00a00513 + 32'(i), 64'h2000 + 64'(4 * i), 1'b0, 1'b0);
    checks++;
    if (out_count !== 3'd3) begin
      errors++;
      $display("FAIL flush_pre got cnt=%0d exp 3", out_count);
    end
    drive_cycle(1'b1, 32'h00b00593, 64'h200c, 1'b1, 1'b1);
    checks++;
    if (out_valid !== 1'b0 || out_count !== 3'd0 || out_fetch_enable !== 1'b1) begin
      errors++;
      $display("FAIL flush_after got v=%b cnt=%0d fe=%b exp 0 0 1", out_valid, out_count, out_fetch_enable);
    end
    drive_cycle(1'b1, 32'h00c00613, 64'h8004, 1'b0, 1'b0);
    checks++;
    if (out_count !== 3'd1 || out_instruction_bits !== 32'h00c00613) begin
      errors++;
      $display("FAIL flush_redirect got cnt=%0d ins=%h exp 1 00c00613", out_count, out_instruction_bits);
    end
    drive_cycle(1'b0, '0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_halt();
    drive_cycle(1'b1, INSTR_NOP, 64'h304, 1'b0, 1'b0);
    drive_cycle(1'b1, 32'h0, 64'h308, 1'b0, 1'b0);
    checks++;
    if (out_halted !== 1'b1 || out_fetch_enable !== 1'b0 || out_count !== 3'd2) begin
      errors++;
      $display("FAIL halt_set got h=%b fe=%b cnt=%0d exp 1 0 2", out_halted, out_fetch_enable, out_count);
    end
    drive_cycle(1'b1, 32'h00100093, 64'h30c, 1'b0, 1'b0);
    drive_cycle(1'b0, '0, '0, 1'b1, 1'b0);
    drive_cycle(1'b0, '0, '0, 1'b1, 1'b0);
    checks++;
    if (out_count !== 3'd0 || out_halted !== 1'b1 || out_fetch_enable !== 1'b0) begin
      errors++;
      $display("FAIL halt_drained got cnt=%0d h=%b fe=%b exp 0 1 0", out_count, out_halted, out_fetch_enable);
    end
    drive_cycle(1'b0, '0, '0, 1'b0, 1'b1);
    checks++;
    if (out_halted !== 1'b0 || out_fetch_enable !== 1'b1) begin
      errors++;
      $display("FAIL halt_cleared got h=%b fe=%b exp 0 1", out_halted, out_fetch_enable);
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 30; i++)
      drive_cycle(i % 4 != 3, 32'h01000013 + 32'(i << 7), 64'h4000 + 64'(4 * i), i % 3 != 0, 1'b0);
    for (int i = 0; i < 5; i++) drive_cycle(1'b0, '0, '0, 1'b1, 1'b0);
    checks++;
    if (out_count !== 3'd0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL wrap_drained got cnt=%0d left=%0d exp 0 0", out_count, exp_q.size());
    end
  endtask

  task automatic test_count_one();
    drive_cycle(1'b1, 32'h00200293, 64'h5004, 1'b0, 1'b0);
    drive_cycle(1'b1, 32'h00300313, 64'h5008, 1'b1, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || out_count !== 3'd1 || out_instruction_bits !== 32'h00300313) begin
      errors++;
      $display("FAIL count_one got v=%b cnt=%0d ins=%h exp 1 1 00300313", out_valid, out_count, out_instruction_bits);
    end
    drive_cycle(1'b1, 32'h00400393, 64'h0, 1'b1, 1'b0);
    checks++;
    if (out_pc !== 64'hFFFFFFFFFFFFFFFC || out_pcplus1 !== 64'h0) begin
      errors++;
      $display("FAIL pc_underflow got pc=%h exp fffffffffffffffc", out_pc);
    end
    drive_cycle(1'b0, '0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_async_reset();
    drive_cycle(1'b1, INSTR_NOP, 64'h604, 1'b0, 1'b0);
    drive_cycle(1'b1, 32'h0, 64'h608, 1'b0, 1'b0);
    in_valid = 1'b0;
    checks++;
    if (out_count !== 3'd2 || out_halted !== 1'b1) begin
      errors++;
      $display("FAIL areset_pre got cnt=%0d h=%b exp 2 1", out_count, out_halted);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_fetch_enable !== 1'b1 || out_count !== 3'd0 ||
        out_halted !== 1'b0 || out_instruction_bits !== 32'h0 || out_pcplus1 !== 64'h0) begin
      errors++;
      $display("FAIL areset_immediate got v=%b fe=%b cnt=%0d h=%b ins=%h exp 0 1 0 0 0",
               out_valid, out_fetch_enable, out_count, out_halted, out_instruction_bits);
    end
    exp_q.delete();
    exp_halted = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    drive_cycle(1'b1, 32'h00700713, 64'h704, 1'b0, 1'b0);
    drive_cycle(1'b0, '0, '0, 1'b1, 1'b0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    pops   = 0;
    test_reset();
    test_fill();
    test_stream();
    test_flush();
    test_halt();
    test_wrap();
    test_count_one();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_decode_queue.md
# fetch_decode_queue

Instruction queue between the fetch stage and the decode stage of the RISC-V pipeline. It buffers fetched instruction words with their PCs, so cache or TLB stalls and decode back-pressure are decoupled. It empties on branch redirect and latches a halt when an all-zero instruction word is fetched. It drives the fetch stage's enable input and presents first-word-fall-through entries to decode.

## Interface
- DEPTH, 4, number of entries; power of two, at least 2
- ADDRESS_WIDTH, 64, PC width
- INSTRUCTION_WIDTH, 32, instruction word width

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- in_valid  in  1  fetch has a word this cycle (fetch out_ready)
- in_instruction_bits  in  INSTRUCTION_WIDTH  fetched word
- in_pcplus1  in  ADDRESS_WIDTH  fetch's pc+4 for this word
- in_flush  in  1  branch taken; discard all queued and incoming words
- out_fetch_enable  out  1  queue can accept a push (to fetch in_enable)
- in_decode_ready  in  1  decode consumes the head this cycle if out_valid
- out_valid  out  1  head entry present
- out_instruction_bits  out  INSTRUCTION_WIDTH  head word
- out_pc  out  ADDRESS_WIDTH  head PC, equal to stored pcplus1 - 4
- out_pcplus1  out  ADDRESS_WIDTH  head pcplus1
- out_count  out  $clog2(DEPTH)+1  occupancy, 0..DEPTH
- out_halted  out  1  zero word has been accepted; fetch is held off

## Operation
- Storage is a circular buffer of {pcplus1, instruction} with rd_ptr, wr_ptr and count.
- Pointers are $clog2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0.
- out_fetch_enable = !full && !halted, where full = (count == DEPTH).
- Push = in_valid && out_fetch_enable && !in_flush.
  - Writes mem[wr_ptr] and increments wr_ptr.
- Pop = out_valid && in_decode_ready && !in_flush.
  - Increments rd_ptr.
- count next value:
  - push and pop in the same cycle: count unchanged.
  - push only: +1.
  - pop only: -1.
- Simultaneous push and pop when full is impossible, because push requires !full. Pop alone proceeds.
- Simultaneous push and pop when count is 1: the head advances to the new entry, and out_valid stays 1.
- Halt latch:
  - A push whose instruction_bits == 0 sets halted on the same edge.
  - The zero word itself is enqueued and reaches decode in order.
  - halted stays set until a flush or reset.
- Flush has priority over every other event on that edge:
  - rd_ptr, wr_ptr and count go to 0, and halted goes to 0.
  - A coincident in_valid word is dropped.
  - A coincident decode pop is not counted.
- out_pc = out_pcplus1 - 4, modulo 2^ADDRESS_WIDTH (wraps on underflow).
- Head outputs are driven combinationally from mem[rd_ptr] (first-word fall-through). When out_valid = 0, out_instruction_bits, out_pc and out_pcplus1 are forced to 0.
- Block-level states:
  - EMPTY (count 0)
  - PARTIAL
  - FULL (count DEPTH)
  - HALTED, orthogonal to occupancy; exited only by flush or reset.

## Timing
- Reset values: pointers 0, count 0, halted 0, memory contents don't-care.
- Outputs during and after reset:
  - out_valid 0
  - out_fetch_enable 1
  - out_count 0
  - out_halted 0
  - head data 0
- Reset mid-operation takes effect immediately (asynchronous); all queued entries are lost.
- Push-to-head latency: a word pushed at edge N is visible at out_* after edge N, with no added cycle when the queue was empty.
- out_fetch_enable falls in the cycle after the edge that makes count == DEPTH. It rises combinationally in the cycle after the first pop.
- Flush asserted in cycle N: after edge N, out_valid = 0 and out_fetch_enable = 1. The first redirected word can be pushed at edge N+1.
- Throughput: one push and one pop per cycle, sustained.

## Structure
- Shared pipeline package holds:
  - typedef fd_entry_t {pcplus1, instruction}
  - localparam INSTR_NOP = 32'h00000013
  - localparam HALT_WORD = 0
- DEPTH is checked at elaboration: DEPTH >= 2 and a power of two.
- One natural sub-module, fifo_ptr_ctrl: pointer and count bookkeeping, with the flush and push/pop priority logic. The data array stays in fetch_decode_queue.

## Test plan
- Fill without pop: push 0x00500093, 0x00a00113, 0x00f00193, 0x01400213 with pcplus1 = 4, 8, 12, 16.
  - out_count reaches 4 and out_fetch_enable drops.
  - Head stays 0x00500093 with out_pc 0.
  - A 5th in_valid word is ignored.
- Streaming: in_valid and in_decode_ready held high for 20 cycles over 20 distinct words.
  - out_count stays at 1.
  - Decode sees all 20 words in order, with out_pc = pcplus1 - 4.
- Flush mid-stream: count 3, then in_flush together with in_valid and in_decode_ready.
  - Next cycle: out_valid 0, count 0, out_fetch_enable 1.
  - Flushed words never appear at decode.
- Halt: push 0x00000013, then 0x00000000.
  - out_halted = 1 and out_fetch_enable = 0 after the zero push.
  - Both words drain to decode in order.
  - A flush clears the halt.
- Wrap-around and boundaries:
  - Interleave push/pop so pointers wrap at least 3 times with DEPTH=4; data order stays preserved.
  - Push and pop at count 1: out_valid continuous.
  - in_pcplus1 = 0 gives out_pc = 0xFFFFFFFFFFFFFFFC.
- Async reset mid-operation at count 2 and halted.
  - Outputs return to reset values before the next clock edge.
